// File: rtl/vortex_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : bus_protocol_if                                              |
// | Description : Simple AHB-slave-side request/response bundle. The bus       |
// |               protocol block drives wen/ren/addr/wdata/strobe. The         |
// |               peripheral returns rdata/error/request_stall.                |
// | Signals     : wen, ren       write / read request                          |
// |               addr [31:0]    byte address                                  |
// |               wdata[31:0]    write data word                               |
// |               strobe[3:0]    byte strobes within the word                  |
// |               rdata[31:0]    read data (valid when stall drops)            |
// |               error          address outside the local RAM                 |
// |               request_stall  access not finished this cycle                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface bus_protocol_if;
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic [31:0] rdata;
    logic        error;
    logic        request_stall;

    modport peripheral_vital (
        input  wen, ren, addr, wdata, strobe,
        output rdata, error, request_stall
    );

    modport protocol (
        output wen, ren, addr, wdata, strobe,
        input  rdata, error, request_stall
    );
endinterface
`default_nettype wire

// File: rtl/vortex_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vortex_mem_arbiter                                           |
// | Description : Schedules the single-port 512-bit chunk RAM between the      |
// |               Vortex memory interface and the AHB slave. One access per    |
// |               cycle. Vortex wins by default. A starvation counter forces   |
// |               AHB through after MAX_STARVE denied cycles. Vortex read      |
// |               data returns through a credit-protected response FIFO.       |
// | Ports       : clk, nRST (async, active-low)                                |
// |               mem_req_*  Vortex request (valid/ready handshake)            |
// |               mem_rsp_*  Vortex response (FIFO head, valid/ready)          |
// |               bpif       AHB side, peripheral_vital modport                |
// |               ram_*      synchronous RAM port, 1-cycle read latency        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vortex_mem_arbiter #(
    parameter int LOCAL_MEM_SIZE = 15,
    parameter int RSP_FIFO_DEPTH = 4,
    parameter int MAX_STARVE     = 8,
    parameter int TAG_WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        nRST,
    input  logic                        mem_req_valid,
    input  logic                        mem_req_rw,
    input  logic [63:0]                 mem_req_byteen,
    input  logic [25:0]                 mem_req_addr,
    input  logic [511:0]                mem_req_data,
    input  logic [TAG_WIDTH-1:0]        mem_req_tag,
    output logic                        mem_req_ready,
    output logic                        mem_rsp_valid,
    output logic [511:0]                mem_rsp_data,
    output logic [TAG_WIDTH-1:0]        mem_rsp_tag,
    input  logic                        mem_rsp_ready,
    bus_protocol_if.peripheral_vital    bpif,
    output logic                        ram_en,
    output logic                        ram_wen,
    output logic [LOCAL_MEM_SIZE-7:0]   ram_addr,
    output logic [63:0]                 ram_byteen,
    output logic [511:0]                ram_wdata,
    input  logic [511:0]                ram_rdata
);

    localparam int C_AW = LOCAL_MEM_SIZE - 6;
    localparam int C_PW = $clog2(RSP_FIFO_DEPTH);
    localparam int C_SW = $clog2(MAX_STARVE + 1);
    localparam logic [C_PW:0]   C_CNT_ONE = (C_PW+1)'(1);
    localparam logic [C_PW-1:0] C_PTR_ONE = C_PW'(1);
    localparam logic [C_SW-1:0] C_STV_ONE = C_SW'(1);
    localparam logic [C_SW-1:0] C_STV_MAX = C_SW'(MAX_STARVE);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        AHB_RD = 1'b1
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_ahb_lane;
    logic [C_SW-1:0]        r_starve;
    logic                   r_rd_pending;
    logic [TAG_WIDTH-1:0]   r_rd_tag;
    logic [C_PW:0]          r_count;
    logic [C_PW-1:0]        r_wr_ptr;
    logic [C_PW-1:0]        r_rd_ptr;
    logic [511:0]           r_fifo_data [RSP_FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]   r_fifo_tag  [RSP_FIFO_DEPTH];

    logic                   w_ahb_err;
    logic                   w_ahb_act;
    logic                   w_ahb_req;
    logic [C_PW+1:0]        w_occ;
    logic                   w_vx_space;
    logic                   w_vx_elig;
    logic                   w_ahb_grant;
    logic                   w_vx_grant;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_unused_bits;

    // Address bits that never reach the RAM.
    assign w_unused_bits = ^{bpif.addr[1:0], mem_req_addr[25:C_AW]};

    assign w_ahb_err = |bpif.addr[31:LOCAL_MEM_SIZE];
    assign w_ahb_act = (bpif.wen | bpif.ren) & ~w_ahb_err;
    assign w_ahb_req = w_ahb_act & (r_state == IDLE);

    // Reads in flight (RAM pipeline + FIFO) must never exceed the FIFO depth,
    // so every granted read has a guaranteed slot when its data returns.
    assign w_occ      = {1'b0, r_count} + (C_PW+2)'(r_rd_pending);
    assign w_vx_space = w_occ < (C_PW+2)'(RSP_FIFO_DEPTH);
    assign w_vx_elig  = mem_req_valid & (mem_req_rw | w_vx_space);

    assign w_ahb_grant = w_ahb_req & (~w_vx_elig | (r_starve == C_STV_MAX));
    assign w_vx_grant  = w_vx_elig & ~w_ahb_grant;

    assign mem_req_ready = w_vx_grant;

    assign w_push = r_rd_pending;
    assign w_pop  = mem_rsp_valid & mem_rsp_ready;

    assign mem_rsp_valid = (r_count != '0);
    assign mem_rsp_data  = mem_rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign mem_rsp_tag   = mem_rsp_valid ? r_fifo_tag[r_rd_ptr]  : '0;

    // A write finishes in its grant cycle; a read finishes in AHB_RD.
    assign bpif.error         = w_ahb_err;
    assign bpif.request_stall = w_ahb_act & (r_state == IDLE) & ~(w_ahb_grant & bpif.wen);
    assign bpif.rdata         = (r_state == AHB_RD) ? ram_rdata[{r_ahb_lane, 5'b00000} +: 32] : '0;

    always_comb begin
        ram_en     = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_byteen = '0;
        ram_wdata  = '0;
        if (w_ahb_grant) begin
            ram_en     = 1'b1;
            ram_wen    = bpif.wen;
            ram_addr   = bpif.addr[LOCAL_MEM_SIZE-1:6];
            ram_byteen = bpif.wen ? ({60'd0, bpif.strobe} << {bpif.addr[5:2], 2'b00}) : '0;
            ram_wdata  = {16{bpif.wdata}};
        end else if (w_vx_grant) begin
            ram_en     = 1'b1;
            ram_wen    = mem_req_rw;
            ram_addr   = mem_req_addr[C_AW-1:0];
            ram_byteen = mem_req_rw ? mem_req_byteen : '0;
            ram_wdata  = mem_req_data;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_ahb_lane   <= '0;
            r_starve     <= '0;
            r_rd_pending <= 1'b0;
            r_rd_tag     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ahb_grant && !bpif.wen) begin
                        r_state    <= AHB_RD;
                        r_ahb_lane <= bpif.addr[5:2];
                    end
                end
                AHB_RD:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_ahb_grant) begin
                r_starve <= '0;
            end else if (w_ahb_req && (r_starve != C_STV_MAX)) begin
                r_starve <= r_starve + C_STV_ONE;
            end

            r_rd_pending <= w_vx_grant & ~mem_req_rw;
            if (w_vx_grant && !mem_req_rw) begin
                r_rd_tag <= mem_req_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= ram_rdata;
            r_fifo_tag[r_wr_ptr]  <= r_rd_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vortex_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vortex_mem_arbiter                                        |
// | Description : Bench for vortex_mem_arbiter with a RAM model, a reference   |
// |               memory image and a response scoreboard.                      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_vortex_mem_arbiter;
    localparam int LMS   = 15;
    localparam int DEPTH = 4;
    localparam int MAXS  = 8;
    localparam int NCH   = 1 << (LMS - 6);

    logic clk = 1'b0;
    logic nRST = 1'b0;
    logic         mem_req_valid = 1'b0, mem_req_rw = 1'b0;
    logic [63:0]  mem_req_byteen = '0;
    logic [25:0]  mem_req_addr = '0;
    logic [511:0] mem_req_data = '0;
    logic [7:0]   mem_req_tag = '0;
    logic         mem_req_ready, mem_rsp_valid, mem_rsp_ready;
    logic [511:0] mem_rsp_data;
    logic [7:0]   mem_rsp_tag;
    logic         ram_en, ram_wen;
    logic [8:0]   ram_addr;
    logic [63:0]  ram_byteen;
    logic [511:0] ram_wdata, ram_rdata;

    bus_protocol_if bpif();

    vortex_mem_arbiter #(.LOCAL_MEM_SIZE(LMS), .RSP_FIFO_DEPTH(DEPTH),
                         .MAX_STARVE(MAXS), .TAG_WIDTH(8)) dut (
        .clk(clk), .nRST(nRST),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .mem_rsp_ready(mem_rsp_ready), .bpif(bpif),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_byteen(ram_byteen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, n_pop = 0;
    int rsp_mode = 0;                 // 0: ready low, 1: ready high, 2: random
    logic [7:0] tag_ctr = 8'h80;

    typedef struct packed { logic [511:0] d; logic [7:0] t; } rsp_t;
    rsp_t         exp_q[$];
    logic [511:0] ref_mem [NCH];
    logic [511:0] ram [NCH];

    function automatic logic [511:0] pat(int i);
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = 32'(i) * 32'h9E3779B1 + 32'(w) * 32'h01000193;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Synchronous RAM, 1-cycle read latency.
    initial begin
        for (int i = 0; i < NCH; i++) ram[i] = pat(i);
        ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_wen) begin
                    for (int b = 0; b < 64; b++)
                        if (ram_byteen[b]) ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end else begin
                    ram_rdata <= ram[ram_addr];
                end
            end
        end
    end

    initial begin
        mem_rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            mem_rsp_ready = (rsp_mode == 1) ? 1'b1 :
                            (rsp_mode == 2) ? ($urandom_range(0, 9) < 7) : 1'b0;
        end
    end

    // Reference model + scoreboard: observes handshakes each cycle.
    initial begin
        int stall_run;
        bit ahb_wr_done;
        logic [8:0] ch;
        logic [3:0] ln;
        rsp_t r;
        stall_run = 0;
        for (int i = 0; i < NCH; i++) ref_mem[i] = pat(i);
        forever begin
            @(negedge clk);
            #2;
            if (!nRST) begin
                exp_q.delete();
                stall_run = 0;
                continue;
            end
            ahb_wr_done = 1'b0;
            if (bpif.wen || bpif.ren) begin
                ch = bpif.addr[LMS-1:6];
                ln = bpif.addr[5:2];
                if (bpif.addr[31:LMS] != 0) begin
                    chk("err_flag", bpif.error, 1'b1);
                    chk("err_stall", bpif.request_stall, 1'b0);
                    chk("err_rdata", bpif.rdata, 32'h0);
                end else begin
                    chk("inrange_err_flag", bpif.error, 1'b0);
                    if (bpif.request_stall) begin
                        stall_run++;
                    end else begin
                        n_cmp++;
                        if (stall_run > MAXS + 1) begin
                            n_bad++;
                            $display("FAIL ahb_starve_bound: stalled=%0d allowed=%0d", stall_run, MAXS + 1);
                        end
                        stall_run = 0;
                        if (bpif.wen) begin
                            for (int k = 0; k < 4; k++)
                                if (bpif.strobe[k]) ref_mem[ch][(ln*4+k)*8 +: 8] = bpif.wdata[k*8 +: 8];
                            ahb_wr_done = 1'b1;
                        end else begin
                            chk("ahb_rdata", bpif.rdata, ref_mem[ch][ln*32 +: 32]);
                        end
                    end
                end
            end
            if (mem_req_ready) begin
                if (!mem_req_valid || ahb_wr_done) begin
                    n_cmp++; n_bad++;
                    $display("FAIL vx_ready_illegal: ready=1 valid=%0d ahb_write_same_cycle=%0d",
                             mem_req_valid, ahb_wr_done);
                end else if (mem_req_rw) begin
                    for (int b = 0; b < 64; b++)
                        if (mem_req_byteen[b]) ref_mem[mem_req_addr[8:0]][b*8 +: 8] = mem_req_data[b*8 +: 8];
                end else begin
                    exp_q.push_back({ref_mem[mem_req_addr[8:0]], mem_req_tag});
                    n_cmp++;
                    if (exp_q.size() > DEPTH) begin
                        n_bad++;
                        $display("FAIL vx_credit: outstanding=%0d limit=%0d", exp_q.size(), DEPTH);
                    end
                end
            end
            if (mem_rsp_valid && mem_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rsp_spurious: tag=%0h expected no response", mem_rsp_tag);
                end else begin
                    r = exp_q.pop_front();
                    chk("rsp_data", mem_rsp_data, r.d);
                    chk("rsp_tag", mem_rsp_tag, r.t);
                    n_pop++;
                end
            end
        end
    end

    task automatic rand_data(output logic [511:0] d);
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    endtask

    task automatic vx_issue(input bit rw, input logic [8:0] a, input logic [63:0] be,
                            input logic [511:0] d, input logic [7:0] t);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = {17'd0, a};
        mem_req_byteen = be; mem_req_data = d; mem_req_tag = t;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (mem_req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin n_cmp++; n_bad++; $display("FAIL vx_accept_timeout: addr=%0h", a); end
    endtask

    task automatic vx_idle();
        @(negedge clk);
        mem_req_valid = 1'b0;
    endtask

    task automatic ahb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st, output logic [31:0] rd, output int stalls);
        bit ok;
        ok = 1'b0; stalls = 0; rd = '0;
        @(negedge clk);
        bpif.wen = wr; bpif.ren = !wr; bpif.addr = a; bpif.wdata = wd; bpif.strobe = st;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (!bpif.request_stall) begin ok = 1'b1; rd = bpif.rdata; break; end
            stalls++;
            @(negedge clk);
        end
        if (!ok) begin n_cmp++; n_bad++; $display("FAIL ahb_timeout: addr=%0h", a); end
        @(negedge clk);
        bpif.wen = 1'b0; bpif.ren = 1'b0;
    endtask

    task automatic starve_run(input logic [31:0] a);
        int ready_run, stalls;
        bit blocked, acc, ok;
        logic [511:0] d;
        ready_run = 0; stalls = 0; blocked = 0; acc = 0; ok = 0;
        @(negedge clk);
        bpif.ren = 1'b1; bpif.wen = 1'b0; bpif.addr = a;
        rand_data(d);
        mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = 26'(20 + $urandom_range(0, 3));
        mem_req_byteen = {$urandom, $urandom}; mem_req_data = d;
        for (int i = 0; i < 40; i++) begin
            #2;
            acc = mem_req_ready;
            if (!blocked) begin
                if (acc) ready_run++; else blocked = 1'b1;
            end
            if (!bpif.request_stall) begin ok = 1'b1; break; end
            stalls++;
            @(negedge clk);
            if (acc) begin
                rand_data(d);
                mem_req_data = d; mem_req_byteen = {$urandom, $urandom};
                mem_req_addr = 26'(20 + $urandom_range(0, 3));
            end
        end
        @(negedge clk);
        bpif.ren = 1'b0; mem_req_valid = 1'b0;
        chk("starve_completed", ok, 1'b1);
        chk("starve_vx_cycles_before_ahb", ready_run, MAXS);
        chk("starve_ahb_stall_cycles", stalls, MAXS + 1);
    endtask

    task automatic rand_vx(input int cycles);
        bit hold;
        logic [31:0] r;
        logic [511:0] d;
        hold = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (!hold) begin
                if ($urandom_range(0, 9) < 6) begin
                    r = $urandom; r[8:0] = 9'($urandom_range(0, 7));
                    rand_data(d);
                    mem_req_valid = 1'b1; mem_req_rw = 1'($urandom_range(0, 1));
                    mem_req_addr = r[25:0]; mem_req_byteen = {$urandom, $urandom};
                    mem_req_data = d; mem_req_tag = tag_ctr; tag_ctr = tag_ctr + 8'd1;
                end else begin
                    mem_req_valid = 1'b0;
                end
            end
            #2;
            hold = mem_req_valid && !mem_req_ready;
        end
        @(negedge clk);
        mem_req_valid = 1'b0;
    endtask

    task automatic rand_ahb(input int n);
        logic [31:0] a, rd;
        int st;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_8000;
            else a = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 15)) << 2);
            ahb_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), rd, st);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int st, acc, pops0;
        logic [511:0] exp1;
        bpif.wen = 1'b0; bpif.ren = 1'b0; bpif.addr = '0; bpif.wdata = '0; bpif.strobe = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rsp_valid", mem_rsp_valid, 1'b0);
        chk("reset_rsp_data", mem_rsp_data, '0);
        chk("reset_rsp_tag", mem_rsp_tag, 8'h0);
        chk("reset_ram_en", ram_en, 1'b0);
        chk("reset_ahb_rdata", bpif.rdata, 32'h0);
        @(negedge clk);
        nRST = 1'b1;

        // Read of chunk 5: response two cycles after acceptance.
        rsp_mode = 1;
        vx_issue(1'b0, 9'd5, '0, '0, 8'h5A);
        vx_idle();
        #2;
        chk("t1_valid_plus1", mem_rsp_valid, 1'b0);
        @(negedge clk); #2;
        chk("t1_valid_plus2", mem_rsp_valid, 1'b1);
        chk("t1_tag", mem_rsp_tag, 8'h5A);
        chk("t1_data", mem_rsp_data, pat(5));

        // Back-to-back reads with no response drain: only DEPTH accepted.
        rsp_mode = 0;
        repeat (2) @(negedge clk);
        pops0 = n_pop; acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mem_req_valid = 1'b1; mem_req_rw = 1'b0;
            mem_req_addr = 26'(10 + acc); mem_req_tag = 8'(8'h20 + acc);
            #2;
            if (mem_req_ready) acc++;
        end
        vx_idle();
        chk("t2_accepted", acc, DEPTH);
        rsp_mode = 1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk); #3;
        chk("t2_drained", n_pop - pops0, DEPTH);

        // AHB partial write then read back.
        vx_issue(1'b1, 9'd1, {64{1'b1}}, '0, 8'h00);
        vx_idle();
        ahb_xfer(1'b1, 32'h44, 32'hDEADBEEF, 4'b0011, rd, st);
        chk("t3_wr_stalls", st, 0);
        ahb_xfer(1'b0, 32'h44, '0, '0, rd, st);
        chk("t3_rd_data", rd, 32'h0000BEEF);
        chk("t3_rd_stalls", st, 1);
        ahb_xfer(1'b0, 32'h40, '0, '0, rd, st);
        chk("t3_rd_word0", rd, 32'h0);
        exp1 = '0; exp1[47:32] = 16'hBEEF;
        vx_issue(1'b0, 9'd1, '0, '0, 8'h77);
        vx_idle();
        @(negedge clk); #2;
        chk("t3_vx_chunk1", mem_rsp_data, exp1);

        // Starvation guarantee, twice to show the counter restarts.
        starve_run(32'h0000_0480);
        starve_run(32'h0000_04C4);

        // Out-of-range AHB access.
        @(negedge clk);
        bpif.ren = 1'b1; bpif.addr = 32'h0001_0000;
        #2;
        chk("t5_error", bpif.error, 1'b1);
        chk("t5_stall", bpif.request_stall, 1'b0);
        chk("t5_rdata", bpif.rdata, 32'h0);
        chk("t5_ram_en", ram_en, 1'b0);
        @(negedge clk);
        bpif.ren = 1'b0;

        // Reset with two responses queued.
        rsp_mode = 0;
        vx_issue(1'b0, 9'd30, '0, '0, 8'h61);
        vx_issue(1'b0, 9'd31, '0, '0, 8'h62);
        vx_idle();
        repeat (3) @(negedge clk);
        #2;
        chk("t6_queued_valid", mem_rsp_valid, 1'b1);
        @(negedge clk); #1;
        nRST = 1'b0;
        #1;
        chk("t6_valid_in_reset", mem_rsp_valid, 1'b0);
        chk("t6_data_in_reset", mem_rsp_data, '0);
        rsp_mode = 1;
        @(negedge clk);
        nRST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("t6_no_stale", mem_rsp_valid, 1'b0);
            @(negedge clk);
        end

        // Randomised concurrent traffic.
        rsp_mode = 2;
        fork
            rand_vx(1500);
            rand_ahb(150);
        join
        rsp_mode = 1;
        mem_req_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk); #3;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
